path_delay_probe: RTL and testbench

Launch/capture controller for the spy delay-measurement flow: drives the input of a path-under-test, such as a benchmark single-path netlist with or without an inserted trojan. It times, in clock cycles, how long the launched transition takes to appear at the path output. It repeats the measurement for a programmed number of trials, reports min/max/sum statistics, and raises an alarm when the measured delay leaves a golden window. It sits between the test sequencer and the path-under-test, one instance per monitored path.

---
 rtl/spy_pkg.sv | 23 ++
 rtl/spy_sync2.sv | 21 ++
 rtl/path_delay_probe.sv | 131 +++++++++++++
 tb/tb_path_delay_probe.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spy_pkg.sv
// Shared types and defaults for the spy delay-measurement blocks.
package spy_pkg;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TRIALS  = 16;
  localparam int DEF_SETTLE  = 32;
  localparam int DEF_TIMEOUT = 255;
  localparam int SUM_W       = DEF_CNT_W + $clog2(DEF_TRIALS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_RECORD  = 3'd4,
    ST_DONE    = 3'd5
  } spy_state_e;

  function automatic int sum_width(input int cnt_w, input int trials);
    return cnt_w + $clog2(trials);
  endfunction

endpackage

// File: rtl/spy_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, async active-high reset.
module spy_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/path_delay_probe.sv
// Launches alternating transitions into a path-under-test, counts cycles until the
// synchronized output follows, and accumulates min/max/sum over a run of trials.
module path_delay_probe
  import spy_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TRIALS  = DEF_TRIALS,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [CNT_W-1:0]                 golden_lo,
  input  logic [CNT_W-1:0]                 golden_hi,
  input  logic                             path_out,
  output logic                             launch,
  output logic                             busy,
  output logic                             done,
  output logic [CNT_W-1:0]                 delay_min,
  output logic [CNT_W-1:0]                 delay_max,
  output logic [CNT_W+$clog2(TRIALS)-1:0]  delay_sum,
  output logic                             timeout_err,
  output logic                             alarm
);

  localparam int SW   = CNT_W + $clog2(TRIALS);
  localparam int TR_W = $clog2(TRIALS);
  localparam int ST_W = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] TMO         = CNT_W'(TIMEOUT);
  localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'(SETTLE - 1);
  localparam logic [TR_W-1:0]  TRIAL_LAST  = TR_W'(TRIALS - 1);

  spy_state_e       state;
  logic             sync_q;
  logic             baseline;
  logic             tmo_hit;
  logic [CNT_W-1:0] cnt;
  logic [ST_W-1:0]  settle_cnt;
  logic [TR_W-1:0]  trial;

  spy_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (path_out),
    .q   (sync_q)
  );

  // start is a one-cycle request honoured only in IDLE; busy covers the whole
  // run including the DONE cycle, and done pulses exactly once in that cycle.
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      launch      <= 1'b0;
      baseline    <= 1'b0;
      tmo_hit     <= 1'b0;
      cnt         <= '0;
      settle_cnt  <= '0;
      trial       <= '0;
      delay_min   <= '1;
      delay_max   <= '0;
      delay_sum   <= '0;
      timeout_err <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_SETTLE;
            settle_cnt  <= '0;
            trial       <= '0;
            delay_min   <= '1;
            delay_max   <= '0;
            delay_sum   <= '0;
            timeout_err <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            baseline   <= sync_q;
            settle_cnt <= '0;
            state      <= ST_LAUNCH;
          end else begin
            settle_cnt <= settle_cnt + ST_W'(1);
          end
        end
        ST_LAUNCH: begin
          // Level is never restored, so successive trials alternate edge direction.
          launch  <= ~launch;
          cnt     <= CNT_W'(1);
          tmo_hit <= 1'b0;
          state   <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (sync_q != baseline) begin
            state <= ST_RECORD;
          end else if (cnt == TMO) begin
            tmo_hit <= 1'b1;
            state   <= ST_RECORD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RECORD: begin
          if (tmo_hit) begin
            timeout_err <= 1'b1;
          end else begin
            if (cnt < delay_min) delay_min <= cnt;
            if (cnt > delay_max) delay_max <= cnt;
            delay_sum <= delay_sum + SW'(cnt);
          end
          if (trial == TRIAL_LAST) begin
            state <= ST_DONE;
          end else begin
            trial <= trial + TR_W'(1);
            state <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          alarm <= timeout_err | (delay_min < golden_lo) | (delay_max > golden_hi);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_delay_probe.sv
// Bench for path_delay_probe: a behavioural path model delays each launch edge by a
// chosen number of clocks, and a reference model predicts counts, statistics and run length.
module tb_path_delay_probe;

  localparam int CNT_W   = 8;
  localparam int TRIALS  = 16;
  localparam int SETTLE  = 32;
  localparam int TIMEOUT = 255;
  localparam int SUM_W   = CNT_W + $clog2(TRIALS);
  localparam int MAX_CYC = 20000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] golden_lo;
  logic [CNT_W-1:0] golden_hi;
  logic             path_out;
  logic             launch;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] delay_min;
  logic [CNT_W-1:0] delay_max;
  logic [SUM_W-1:0] delay_sum;
  logic             timeout_err;
  logic             alarm;

  path_delay_probe #(
    .CNT_W(CNT_W), .TRIALS(TRIALS), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .golden_lo   (golden_lo),
    .golden_hi   (golden_hi),
    .path_out    (path_out),
    .launch      (launch),
    .busy        (busy),
    .done        (done),
    .delay_min   (delay_min),
    .delay_max   (delay_max),
    .delay_sum   (delay_sum),
    .timeout_err (timeout_err),
    .alarm       (alarm)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- path model ----------------
  // mode 0: path_out wired to launch; 1: delayed model; 2: stuck at 0
  int   mode = 0;
  logic path_model = 1'b0;
  int   delay_q[$];

  assign path_out = (mode == 0) ? launch : (mode == 1) ? path_model : 1'b0;

  initial begin
    forever begin
      logic lvl;
      int   d;
      @(launch);
      lvl = launch;
      d = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
      repeat (d) @(posedge clk);
      #1 path_model = lvl;
    end
  end

  // ---------------- reference model ----------------
  // trial_d[t] = clocks after launch at which the output change lands; -1 = never.
  int               trial_d[TRIALS];
  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_min;
  logic [CNT_W-1:0] exp_max;
  logic [SUM_W-1:0] exp_sum;
  logic             exp_tmo;
  logic             exp_alarm;
  int               exp_len;

  task automatic ref_model(input logic [CNT_W-1:0] lo, input logic [CNT_W-1:0] hi);
    int c;
    exp_q.delete();
    exp_tmo = 1'b0;
    exp_len = 1;
    for (int t = 0; t < TRIALS; t++) begin
      c = trial_d[t] + 3;
      if (trial_d[t] < 0 || c > TIMEOUT) begin
        exp_tmo = 1'b1;
        exp_len += SETTLE + 1 + TIMEOUT + 1;
      end else begin
        exp_q.push_back(CNT_W'(c));
        exp_len += SETTLE + 1 + c + 1;
      end
    end
    exp_min = '1;
    exp_max = '0;
    exp_sum = '0;
    foreach (exp_q[i]) begin
      if (exp_q[i] < exp_min) exp_min = exp_q[i];
      if (exp_q[i] > exp_max) exp_max = exp_q[i];
      exp_sum = exp_sum + SUM_W'(exp_q[i]);
    end
    exp_alarm = exp_tmo || (exp_min < lo) || (exp_max > hi);
  endtask

  task automatic load_delays();
    delay_q.delete();
    for (int t = 0; t < TRIALS; t++) delay_q.push_back(trial_d[t]);
  endtask

  // ---------------- driver ----------------
  int run_cycles;
  int run_dones;
  int run_toggles;

  task automatic do_run(input int extra_start_at);
    logic prev;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_cycles  = 0;
    run_dones   = 0;
    run_toggles = 0;
    prev = launch;
    while (busy === 1'b1 && run_cycles < MAX_CYC) begin
      if (done === 1'b1) run_dones++;
      if (launch !== prev) run_toggles++;
      prev = launch;
      start = (run_cycles == extra_start_at) ? 1'b1 : 1'b0;
      run_cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    if (launch !== prev) run_toggles++;
    checks++;
    if (run_cycles >= MAX_CYC) begin
      errors++;
      $display("FAIL run_bound: busy still high after %0d cycles, required below %0d", run_cycles, MAX_CYC);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    golden_lo = '0;
    golden_hi = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({launch, busy, done, timeout_err, alarm} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got launch/busy/done/tmo/alarm=%b required 00000", {launch, busy, done, timeout_err, alarm});
    end
    checks++;
    if (delay_min !== 8'hff) begin errors++; $display("FAIL reset_min: got %0d required 255", delay_min); end
    checks++;
    if (delay_max !== 8'h00 || delay_sum !== '0) begin
      errors++;
      $display("FAIL reset_max_sum: got max=%0d sum=%0d required 0 0", delay_max, delay_sum);
    end
  endtask

  task automatic test_fixed_delay();
    mode = 1;
    golden_lo = 8'd6;
    golden_hi = 8'd10;
    for (int t = 0; t < TRIALS; t++) trial_d[t] = 5;
    load_delays();
    ref_model(golden_lo, golden_hi);
    do_run(-1);
    checks++;
    if (delay_min !== exp_min || delay_max !== exp_max) begin
      errors++;
      $display("FAIL fixed_minmax: got %0d/%0d required %0d/%0d", delay_min, delay_max, exp_min, exp_max);
    end
    checks++;
    if (delay_sum !== exp_sum) begin errors++; $display("FAIL fixed_sum: got %0d required %0d", delay_sum, exp_sum); end
    checks++;
    if (alarm !== exp_alarm || timeout_err !== exp_tmo) begin
      errors++;
      $display("FAIL fixed_alarm: got alarm=%b tmo=%b required %b %b", alarm, timeout_err, exp_alarm, exp_tmo);
    end
    checks++;
    if (run_cycles !== exp_len) begin errors++; $display("FAIL fixed_len: got %0d required %0d", run_cycles, exp_len); end
    checks++;
    if (run_dones !== 1) begin errors++; $display("FAIL fixed_done: got %0d pulses required 1", run_dones); end
  endtask

  task automatic test_direct_wire();
    logic lvl0;
    mode = 0;
    delay_q.delete();
    golden_lo = 8'd3;
    golden_hi = 8'd3;
    lvl0 = launch;
    for (int t = 0; t < TRIALS; t++) trial_d[t] = 0;
    ref_model(golden_lo, golden_hi);
    do_run(-1);
    checks++;
    if (delay_min !== exp_min || delay_max !== exp_max || delay_sum !== exp_sum) begin
      errors++;
      $display("FAIL direct_stats: got %0d/%0d/%0d required %0d/%0d/%0d",
               delay_min, delay_max, delay_sum, exp_min, exp_max, exp_sum);
    end
    checks++;
    if (run_toggles !== TRIALS || launch !== lvl0) begin
      errors++;
      $display("FAIL direct_launch: got %0d toggles level %b required %0d level %b", run_toggles, launch, TRIALS, lvl0);
    end
    checks++;
    if (alarm !== exp_alarm || run_cycles !== exp_len) begin
      errors++;
      $display("FAIL direct_alarm_len: got %b/%0d required %b/%0d", alarm, run_cycles, exp_alarm, exp_len);
    end
  endtask

  task automatic test_rise_fall();
    logic lvl;
    mode = 1;
    golden_lo = 8'd6;
    golden_hi = 8'd10;
    lvl = launch;
    for (int t = 0; t < TRIALS; t++) begin
      lvl = ~lvl;
      trial_d[t] = lvl ? 5 : 9;
    end
    load_delays();
    ref_model(golden_lo, golden_hi);
    do_run(-1);
    checks++;
    if (delay_min !== exp_min || delay_max !== exp_max || delay_sum !== exp_sum) begin
      errors++;
      $display("FAIL risefall_stats: got %0d/%0d/%0d required %0d/%0d/%0d",
               delay_min, delay_max, delay_sum, exp_min, exp_max, exp_sum);
    end
    checks++;
    if (alarm !== exp_alarm) begin errors++; $display("FAIL risefall_alarm: got %b required %b", alarm, exp_alarm); end
  endtask

  task automatic test_random();
    mode = 1;
    for (int it = 0; it < 3; it++) begin
      golden_lo = CNT_W'($urandom_range(3, 12));
      golden_hi = CNT_W'($urandom_range(20, 45));
      for (int t = 0; t < TRIALS; t++) trial_d[t] = $urandom_range(0, 40);
      load_delays();
      ref_model(golden_lo, golden_hi);
      do_run(-1);
      checks++;
      if (delay_min !== exp_min || delay_max !== exp_max || delay_sum !== exp_sum) begin
        errors++;
        $display("FAIL random_stats[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d", it,
                 delay_min, delay_max, delay_sum, exp_min, exp_max, exp_sum);
      end
      checks++;
      if (alarm !== exp_alarm || run_cycles !== exp_len) begin
        errors++;
        $display("FAIL random_alarm_len[%0d]: got %b/%0d required %b/%0d", it, alarm, run_cycles, exp_alarm, exp_len);
      end
    end
  endtask

  task automatic test_back_to_back();
    mode = 1;
    golden_lo = 8'd3;
    golden_hi = 8'd40;
    for (int t = 0; t < TRIALS; t++) trial_d[t] = $urandom_range(0, 20);
    load_delays();
    ref_model(golden_lo, golden_hi);
    do_run(10);
    checks++;
    if (run_dones !== 1 || run_cycles !== exp_len) begin
      errors++;
      $display("FAIL b2b_first: got %0d dones %0d cycles required 1 %0d", run_dones, run_cycles, exp_len);
    end
    for (int t = 0; t < TRIALS; t++) trial_d[t] = $urandom_range(0, 20);
    load_delays();
    ref_model(golden_lo, golden_hi);
    do_run(exp_len - 1);
    checks++;
    if (run_dones !== 1 || delay_sum !== exp_sum || delay_min !== exp_min || delay_max !== exp_max) begin
      errors++;
      $display("FAIL b2b_second: got dones=%0d %0d/%0d/%0d required 1 %0d/%0d/%0d",
               run_dones, delay_min, delay_max, delay_sum, exp_min, exp_max, exp_sum);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ignored: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_timeout();
    mode = 2;
    delay_q.delete();
    golden_lo = 8'd6;
    golden_hi = 8'd10;
    for (int t = 0; t < TRIALS; t++) trial_d[t] = -1;
    ref_model(golden_lo, golden_hi);
    do_run(-1);
    checks++;
    if (timeout_err !== 1'b1 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flags: got tmo=%b alarm=%b required 1 1", timeout_err, alarm);
    end
    checks++;
    if (delay_min !== exp_min || delay_max !== exp_max || delay_sum !== exp_sum) begin
      errors++;
      $display("FAIL timeout_stats: got %0d/%0d/%0d required %0d/%0d/%0d",
               delay_min, delay_max, delay_sum, exp_min, exp_max, exp_sum);
    end
    checks++;
    if (run_cycles !== 4625) begin errors++; $display("FAIL timeout_len: got %0d required 4625", run_cycles); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    int dones;
    int target;
    mode = 0;
    delay_q.delete();
    // direct wire: each trial is SETTLE+1+3+1 cycles; land inside MEASURE of trial 7
    target = 6 * (SETTLE + 5) + SETTLE + 3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < target && busy === 1'b1) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({launch, busy, done, timeout_err, alarm} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_ctrl: got launch/busy/done/tmo/alarm=%b required 00000", {launch, busy, done, timeout_err, alarm});
    end
    checks++;
    if (delay_min !== 8'hff || delay_max !== 8'h00 || delay_sum !== '0) begin
      errors++;
      $display("FAIL midrst_stats: got %0d/%0d/%0d required 255/0/0", delay_min, delay_max, delay_sum);
    end
    dones = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL midrst_nodone: got %0d pulses required 0", dones); end
    golden_lo = 8'd3;
    golden_hi = 8'd3;
    for (int t = 0; t < TRIALS; t++) trial_d[t] = 0;
    ref_model(golden_lo, golden_hi);
    do_run(-1);
    checks++;
    if (run_dones !== 1 || run_cycles !== exp_len || delay_sum !== exp_sum || alarm !== exp_alarm) begin
      errors++;
      $display("FAIL midrst_rerun: got dones=%0d len=%0d sum=%0d alarm=%b required 1 %0d %0d %b",
               run_dones, run_cycles, delay_sum, alarm, exp_len, exp_sum, exp_alarm);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fixed_delay();
    test_direct_wire();
    test_rise_fall();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
